// File: rtl/alu_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback_buffer
// Brief    : In-order FIFO between the logic ALU and the register-file write
//            port; owns the architectural Z flag and a retired-write counter.
// Revision : 1.0
// ============================================================================
module alu_writeback_buffer #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_zero,
  input  logic [ADDR_W-1:0]          in_dest,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [WIDTH-1:0]           wb_data,
  output logic [ADDR_W-1:0]          wb_dest,
  output logic                       flag_z,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           retired
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_B = c_PTR_W + 1;
  localparam logic [c_CNT_B-1:0] c_FULL = c_CNT_B'(DEPTH);

  logic [WIDTH-1:0]   r_mem_data [DEPTH];
  logic [ADDR_W-1:0]  r_mem_dest [DEPTH];
  logic               r_mem_zero [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_B-1:0] r_count;
  logic               r_flag_z;
  logic [CNT_W-1:0]   r_retired;

  logic w_push;
  logic w_pop;

  // in_ready is a function of r_count only, so no combinational path from wb_ready.
  assign in_ready = (r_count != c_FULL);
  assign wb_valid = (r_count != '0);
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = wb_valid & wb_ready & ~flush;

  assign wb_data  = wb_valid ? r_mem_data[r_rd_ptr] : '0;
  assign wb_dest  = wb_valid ? r_mem_dest[r_rd_ptr] : '0;
  assign flag_z   = r_flag_z;
  assign count    = r_count;
  assign retired  = r_retired;

  // Storage array carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_result;
      r_mem_dest[r_wr_ptr] <= in_dest;
      r_mem_zero[r_wr_ptr] <= in_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_flag_z  <= 1'b0;
      r_retired <= '0;
    end else if (flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_flag_z <= r_mem_zero[r_rd_ptr];
        if (r_retired != '1) begin
          r_retired <= r_retired + CNT_W'(1);
        end
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_B'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_B'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_writeback_buffer
// Brief    : Directed and seeded-stream checks of alu_writeback_buffer.
// Revision : 1.0
// ============================================================================
module tb_alu_writeback_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_result;
  logic        in_zero;
  logic [3:0]  in_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [19:0] wb_data;
  logic [3:0]  wb_dest;
  logic        flag_z;
  logic [2:0]  count;
  logic [15:0] retired;

  int n_vec;
  int n_err;

  typedef struct {
    logic [19:0] data;
    logic [3:0]  dest;
    logic        zero;
  } entry_t;

  alu_writeback_buffer #(
    .WIDTH(20), .DEPTH(4), .ADDR_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_dest(in_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .flag_z(flag_z), .count(count), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [19:0] d, input logic [3:0] a);
    in_valid  = v;
    in_result = d;
    in_zero   = (d == 20'h0);
    in_dest   = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL reset_flag_z got %b exp 0", flag_z); end
    n_vec++; if (retired !== 16'd0) begin n_err++; $display("FAIL reset_retired got %0d exp 0", retired); end
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_vec++; if (wb_data !== 20'h0) begin n_err++; $display("FAIL reset_wb_data got %h exp 00000", wb_data); end
  endtask

  task automatic test_single();
    wb_ready = 1'b1;
    drive(1'b1, 20'h0F0F0, 4'd3);
    tick();
    drive(1'b0, 20'h0, 4'd0);
    n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL single_wb_valid got %b exp 1", wb_valid); end
    n_vec++; if (wb_data !== 20'h0F0F0) begin n_err++; $display("FAIL single_wb_data got %h exp 0f0f0", wb_data); end
    n_vec++; if (wb_dest !== 4'd3) begin n_err++; $display("FAIL single_wb_dest got %0d exp 3", wb_dest); end
    tick();
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count got %0d exp 0", count); end
    n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL single_flag_z got %b exp 0", flag_z); end
    n_vec++; if (retired !== 16'd1) begin n_err++; $display("FAIL single_retired got %0d exp 1", retired); end
  endtask

  task automatic test_fill();
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 20'(i), 4'(i));
      tick();
      n_vec++; if (count !== 3'(i)) begin n_err++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      n_vec++; if (in_ready !== (i < 4)) begin n_err++; $display("FAIL fill_in_ready got %b exp %b", in_ready, (i < 4)); end
    end
    // Fifth word offered while full: must not be taken.
    drive(1'b1, 20'h5, 4'd5);
    tick();
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_hold_count got %0d exp 4", count); end
    wb_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n_vec++; if (wb_data !== 20'(k)) begin n_err++; $display("FAIL fill_order got %h exp %h", wb_data, 20'(k)); end
      n_vec++; if (wb_dest !== 4'(k)) begin n_err++; $display("FAIL fill_dest got %0d exp %0d", wb_dest, k); end
      tick();
      if (k == 2) drive(1'b0, 20'h0, 4'd0);
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_drain_count got %0d exp 0", count); end
    n_vec++; if (retired !== 16'd6) begin n_err++; $display("FAIL fill_retired got %0d exp 6", retired); end
  endtask

  task automatic test_zero_flag();
    wb_ready = 1'b0;
    drive(1'b1, 20'h00000, 4'd1);
    tick();
    drive(1'b1, 20'hFFFFF, 4'd2);
    tick();
    drive(1'b0, 20'h0, 4'd0);
    n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL zero_before got %b exp 0", flag_z); end
    wb_ready = 1'b1;
    tick();
    n_vec++; if (flag_z !== 1'b1) begin n_err++; $display("FAIL zero_first_pop got %b exp 1", flag_z); end
    wb_ready = 1'b0;
    tick();
    n_vec++; if (flag_z !== 1'b1) begin n_err++; $display("FAIL zero_hold got %b exp 1", flag_z); end
    wb_ready = 1'b1;
    tick();
    n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL zero_second_pop got %b exp 0", flag_z); end
    n_vec++; if (retired !== 16'd8) begin n_err++; $display("FAIL zero_retired got %0d exp 8", retired); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    drive(1'b1, 20'hA0000, 4'd0);
    tick();
    drive(1'b1, 20'hA0001, 4'd1);
    tick();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 20'hA0002 + 20'(i), 4'(i + 2));
      n_vec++; if (wb_data !== 20'hA0000 + 20'(i)) begin n_err++; $display("FAIL b2b_order got %h exp %h", wb_data, 20'hA0000 + 20'(i)); end
      tick();
      n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d exp 2", count); end
    end
    drive(1'b0, 20'h0, 4'd0);
    for (int i = 8; i < 10; i++) begin
      n_vec++; if (wb_data !== 20'hA0000 + 20'(i)) begin n_err++; $display("FAIL b2b_drain got %h exp %h", wb_data, 20'hA0000 + 20'(i)); end
      tick();
    end
    n_vec++; if (retired !== 16'd18) begin n_err++; $display("FAIL b2b_retired got %0d exp 18", retired); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    drive(1'b1, 20'h00000, 4'd7);
    tick();
    drive(1'b1, 20'h12345, 4'd8);
    tick();
    drive(1'b1, 20'h23456, 4'd9);
    tick();
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, 20'h34567, 4'd10);
    tick();
    flush = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, 20'h0, 4'd0);
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", count); end
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_wb_valid got %b exp 0", wb_valid); end
    n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL flush_flag_z got %b exp 0", flag_z); end
    n_vec++; if (retired !== 16'd18) begin n_err++; $display("FAIL flush_retired got %0d exp 18", retired); end
    drive(1'b1, 20'h5A5A5, 4'd11);
    tick();
    drive(1'b0, 20'h0, 4'd0);
    n_vec++; if (wb_data !== 20'h5A5A5) begin n_err++; $display("FAIL flush_after_data got %h exp 5a5a5", wb_data); end
    wb_ready = 1'b1;
    tick();
    n_vec++; if (retired !== 16'd19) begin n_err++; $display("FAIL flush_after_retired got %0d exp 19", retired); end
  endtask

  task automatic test_random_stream();
    entry_t      q[$];
    entry_t      e;
    logic [19:0] a, b, r;
    logic        exp_z;
    int          exp_ret;
    int          op;
    logic        do_push, do_pop;
    exp_z   = 1'b0;
    exp_ret = 19;
    void'($urandom(32'h1234_5678));
    for (int cyc = 0; cyc < 120; cyc++) begin
      a  = 20'($urandom);
      b  = 20'($urandom);
      op = int'($urandom_range(0, 3));
      if (op == 1 && $urandom_range(0, 2) == 0) b = ~a;
      if (op == 3 && $urandom_range(0, 2) == 0) b = a;
      case (op)
        0:       r = ~a;
        1:       r = a & b;
        2:       r = a | b;
        default: r = a ^ b;
      endcase
      drive(1'($urandom_range(0, 1)), r, 4'($urandom));
      wb_ready = 1'($urandom_range(0, 1));
      n_vec++; if (wb_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rand_wb_valid cyc %0d got %b exp %b", cyc, wb_valid, (q.size() != 0)); end
      n_vec++; if (in_ready !== (q.size() < 4)) begin n_err++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", cyc, in_ready, (q.size() < 4)); end
      if (q.size() != 0) begin
        n_vec++; if (wb_data !== q[0].data || wb_dest !== q[0].dest) begin n_err++; $display("FAIL rand_head cyc %0d got %h/%0d exp %h/%0d", cyc, wb_data, wb_dest, q[0].data, q[0].dest); end
      end
      do_push = in_valid && (q.size() < 4);
      do_pop  = wb_ready && (q.size() != 0);
      e.data = in_result;
      e.dest = in_dest;
      e.zero = in_zero;
      tick();
      if (do_pop) begin
        exp_z = q[0].zero;
        exp_ret++;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(e);
      n_vec++; if (flag_z !== exp_z) begin n_err++; $display("FAIL rand_flag_z cyc %0d got %b exp %b", cyc, flag_z, exp_z); end
      n_vec++; if (retired !== 16'(exp_ret) || count !== 3'(q.size())) begin n_err++; $display("FAIL rand_state cyc %0d got %0d/%0d exp %0d/%0d", cyc, retired, count, exp_ret, q.size()); end
    end
    drive(1'b0, 20'h0, 4'd0);
    wb_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(1'b1, 20'hBEEF1, 4'd4);
    tick();
    drive(1'b0, 20'h0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (count !== 3'd0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL areset_fifo got %0d/%b exp 0/0", count, wb_valid); end
    n_vec++; if (retired !== 16'd0 || flag_z !== 1'b0) begin n_err++; $display("FAIL areset_regs got %0d/%b exp 0/0", retired, flag_z); end
    n_vec++; if (wb_data !== 20'h0) begin n_err++; $display("FAIL areset_wb_data got %h exp 00000", wb_data); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    wb_ready  = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_zero   = 1'b0;
    in_dest   = '0;
    test_reset();
    test_single();
    test_fill();
    test_zero_flag();
    test_back_to_back();
    test_flush();
    test_random_stream();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
